// File: rtl/gf256_dlog_if.sv
// Request/response bundle for the GF(2^8) discrete-log engine.
// The master drives a start pulse with the element; the slave reports busy,
// the done pulse and the result (log_n, err).
interface gf256_dlog_if;
  logic       start;
  logic [7:0] elem;
  logic       busy;
  logic       done;
  logic [7:0] log_n;
  logic       err;

  modport master (
    output start,
    output elem,
    input  busy,
    input  done,
    input  log_n,
    input  err
  );

  modport slave (
    input  start,
    input  elem,
    output busy,
    output done,
    output log_n,
    output err
  );
endinterface

// File: rtl/gf256_dlog.sv
// Sequential discrete logarithm over GF(2^8) with reduction x^8 + POLY_LO.
// Walks GEN^0, GEN^1, ... one power per clock until the power equals the
// latched element, then reports the exponent with a one-cycle done pulse.
// A zero element has no logarithm and is flagged through err immediately.
module gf256_dlog #(
  parameter logic [7:0] GEN     = 8'h02,
  parameter logic [7:0] POLY_LO = 8'h63
) (
  input logic         clk,
  input logic         rst,
  gf256_dlog_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state_r;
  logic [7:0] acc_r;     // running power GEN^cnt_r
  logic [7:0] cnt_r;     // exponent of acc_r
  logic [7:0] elem_q_r;  // element captured with the accepted start
  logic       busy_r;
  logic       done_r;
  logic [7:0] log_n_r;
  logic       err_r;

  // Shift-and-add field multiply; with GEN=8'h02 synthesis folds it down to
  // a single shift with a conditional XOR of the reduction constant.
  function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] m;
    logic [7:0] q;
    p = 8'h00;
    m = a;
    q = b;
    for (int i = 0; i < 8; i++) begin
      if (q[0]) begin
        p = p ^ m;
      end else begin
        p = p;
      end
      if (m[7]) begin
        m = {m[6:0], 1'b0} ^ POLY_LO;
      end else begin
        m = {m[6:0], 1'b0};
      end
      q = {1'b0, q[7:1]};
    end
    return p;
  endfunction

  // Control FSM and datapath; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      acc_r    <= 8'h01;
      cnt_r    <= 8'd0;
      elem_q_r <= 8'h00;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      log_n_r  <= 8'h00;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            elem_q_r <= bus.elem;
            busy_r   <= 1'b1;
            if (bus.elem == 8'h00) begin
              // Zero is outside the multiplicative group: report at once.
              log_n_r <= 8'h00;
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              err_r   <= 1'b0;
              acc_r   <= 8'h01;
              cnt_r   <= 8'd0;
              state_r <= SEARCH;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        SEARCH: begin
          if (acc_r == elem_q_r) begin
            log_n_r <= cnt_r;
            err_r   <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else if (cnt_r == 8'd254) begin
            // Whole cyclic group walked without a hit: GEN is not primitive.
            log_n_r <= 8'h00;
            err_r   <= 1'b1;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            acc_r <= gfmul(acc_r, GEN);
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          // Result cycle; start is not looked at here, so nothing queues.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.log_n = log_n_r;
  assign bus.err   = err_r;

endmodule
